// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive frame buffer: show-ahead FIFO with error flags and status counters
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter bit DROP_ERR   = 1'b0
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    data_valid,
   input  logic [DATA_WIDTH-1:0]   P_DATA,
   input  logic                    par_err,
   input  logic                    stp_err,
   input  logic                    strt_glitch,
   input  logic                    rd_ready,
   input  logic                    clr_err,
   output logic                    rd_valid,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_par_err,
   output logic                    rd_stp_err,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [7:0]              frm_err_cnt,
   output logic [7:0]              glitch_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          frm_err;
   logic          push_req;
   logic          pop;
   logic          push;
   logic [EW-1:0] head;

   assign frm_err  = data_valid & (par_err | stp_err);
   assign push_req = data_valid & ~(DROP_ERR & (par_err | stp_err));
   assign pop      = rd_valid & rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign push     = push_req & (~full | pop);

   assign rd_valid = (count != '0);
   assign full     = (count == DEPTH_C);
   assign head     = rd_valid ? mem[rd_ptr] : '0;
   assign {rd_par_err, rd_stp_err, rd_data} = head;

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= {par_err, stp_err, P_DATA};
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         frm_err_cnt <= 8'd0;
         glitch_cnt  <= 8'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Clear takes priority over any status event in the same cycle.
         if (clr_err) begin
            overflow    <= 1'b0;
            frm_err_cnt <= 8'd0;
            glitch_cnt  <= 8'd0;
         end else begin
            if (push_req && full && !pop)
               overflow <= 1'b1;
            if (frm_err && frm_err_cnt != 8'hFF)
               frm_err_cnt <= frm_err_cnt + 8'd1;
            if (strt_glitch && glitch_cnt != 8'hFF)
               glitch_cnt <= glitch_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (DROP_ERR=0 and DROP_ERR=1 instances)
module tb_uart_rx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic data_valid = 1'b0, dv1 = 1'b0;
   logic [DW-1:0] p_data = '0;
   logic par_err = 1'b0, stp_err = 1'b0, strt_glitch = 1'b0;
   logic rd_ready = 1'b0, rdy1 = 1'b0, clr_err = 1'b0;

   logic          rd_valid0, rd_par0, rd_stp0, full0, ovf0;
   logic [DW-1:0] rd_data0;
   logic [3:0]    count0;
   logic [7:0]    frm0, glt0;
   logic          rd_valid1, rd_par1, rd_stp1, full1, ovf1;
   logic [DW-1:0] rd_data1;
   logic [3:0]    count1;
   logic [7:0]    frm1, glt1;

   logic [DW+1:0] q0[$];
   logic [DW+1:0] q1[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_ERR(1'b0)) dut0 (
      .CLK(clk), .RST(rst), .data_valid(data_valid), .P_DATA(p_data),
      .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch),
      .rd_ready(rd_ready), .clr_err(clr_err), .rd_valid(rd_valid0),
      .rd_data(rd_data0), .rd_par_err(rd_par0), .rd_stp_err(rd_stp0),
      .full(full0), .count(count0), .overflow(ovf0),
      .frm_err_cnt(frm0), .glitch_cnt(glt0));

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dut1 (
      .CLK(clk), .RST(rst), .data_valid(dv1), .P_DATA(p_data),
      .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch),
      .rd_ready(rdy1), .clr_err(clr_err), .rd_valid(rd_valid1),
      .rd_data(rd_data1), .rd_par_err(rd_par1), .rd_stp_err(rd_stp1),
      .full(full1), .count(count1), .overflow(ovf1),
      .frm_err_cnt(frm1), .glitch_cnt(glt1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if ({rd_valid0, full0, ovf0, count0} !== 7'd0) begin
         miscompares++;
         $display("FAIL reset_status: got valid=%0b full=%0b ovf=%0b count=%0d want 0", rd_valid0, full0, ovf0, count0);
      end
      vectors++;
      if ({frm0, glt0} !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_counters: got frm=%0d glitch=%0d want 0", frm0, glt0);
      end
      vectors++;
      if ({rd_par0, rd_stp0, rd_data0} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_rd_data: got %h want 000", {rd_par0, rd_stp0, rd_data0});
      end
   endtask

   task automatic test_first_byte();
      p_data = 8'hA5; data_valid = 1'b1; rd_ready = 1'b0;
      q0.push_back({2'b00, 8'hA5});
      tick();
      data_valid = 1'b0;
      vectors++;
      if (rd_valid0 !== 1'b1 || {rd_par0, rd_stp0, rd_data0} !== q0[0] || count0 !== 4'd1) begin
         miscompares++;
         $display("FAIL first_byte: got valid=%0b head=%h count=%0d want 1 %h 1", rd_valid0, {rd_par0, rd_stp0, rd_data0}, count0, q0[0]);
      end
      rd_ready = 1'b1;
      tick();
      void'(q0.pop_front());
      vectors++;
      if (rd_valid0 !== 1'b0 || count0 !== 4'd0) begin
         miscompares++;
         $display("FAIL first_drain: got valid=%0b count=%0d want 0 0", rd_valid0, count0);
      end
      // push into empty while rd_ready=1: must not be popped in the same cycle
      p_data = 8'h5A; data_valid = 1'b1;
      q0.push_back({2'b00, 8'h5A});
      tick();
      data_valid = 1'b0;
      vectors++;
      if (count0 !== 4'd1 || rd_data0 !== 8'h5A) begin
         miscompares++;
         $display("FAIL empty_push_no_pop: got count=%0d data=%h want 1 5a", count0, rd_data0);
      end
      tick();
      void'(q0.pop_front());
      rd_ready = 1'b0;
      vectors++;
      if (count0 !== 4'd0) begin
         miscompares++;
         $display("FAIL empty_push_drain: got count=%0d want 0", count0);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         p_data = DW'(i); data_valid = 1'b1;
         q0.push_back({2'b00, DW'(i)});
         tick();
      end
      data_valid = 1'b0;
      vectors++;
      if (full0 !== 1'b1 || count0 !== 4'd8 || ovf0 !== 1'b0) begin
         miscompares++;
         $display("FAIL fill: got full=%0b count=%0d ovf=%0b want 1 8 0", full0, count0, ovf0);
      end
      p_data = 8'hFF; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      vectors++;
      if (ovf0 !== 1'b1 || count0 !== 4'd8 || rd_data0 !== 8'h00) begin
         miscompares++;
         $display("FAIL overflow: got ovf=%0b count=%0d head=%h want 1 8 00", ovf0, count0, rd_data0);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      vectors++;
      if (ovf0 !== 1'b0 || count0 !== 4'd8) begin
         miscompares++;
         $display("FAIL clr_overflow: got ovf=%0b count=%0d want 0 8", ovf0, count0);
      end
   endtask

   task automatic test_full_pop_push();
      p_data = 8'h3C; data_valid = 1'b1; rd_ready = 1'b1;
      vectors++;
      if ({rd_par0, rd_stp0, rd_data0} !== q0[0]) begin
         miscompares++;
         $display("FAIL full_pop_head: got %h want %h", {rd_par0, rd_stp0, rd_data0}, q0[0]);
      end
      tick();
      void'(q0.pop_front());
      q0.push_back({2'b00, 8'h3C});
      data_valid = 1'b0;
      vectors++;
      if (count0 !== 4'd8 || ovf0 !== 1'b0 || full0 !== 1'b1) begin
         miscompares++;
         $display("FAIL full_pop_push: got count=%0d ovf=%0b full=%0b want 8 0 1", count0, ovf0, full0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if (rd_valid0 !== 1'b1 || {rd_par0, rd_stp0, rd_data0} !== q0[0]) begin
            miscompares++;
            $display("FAIL drain_%0d: got valid=%0b head=%h want 1 %h", i, rd_valid0, {rd_par0, rd_stp0, rd_data0}, q0[0]);
         end
         tick();
         void'(q0.pop_front());
      end
      rd_ready = 1'b0;
      vectors++;
      if (rd_valid0 !== 1'b0 || count0 !== 4'd0) begin
         miscompares++;
         $display("FAIL drain_empty: got valid=%0b count=%0d want 0 0", rd_valid0, count0);
      end
   endtask

   task automatic test_drop_err();
      p_data = 8'h11; par_err = 1'b1; dv1 = 1'b1;
      tick();
      p_data = 8'h22; par_err = 1'b0;
      q1.push_back({2'b00, 8'h22});
      tick();
      dv1 = 1'b0;
      vectors++;
      if (count1 !== 4'd1 || {rd_par1, rd_stp1, rd_data1} !== q1[0] || frm1 !== 8'd1) begin
         miscompares++;
         $display("FAIL drop_err: got count=%0d head=%h frm=%0d want 1 %h 1", count1, {rd_par1, rd_stp1, rd_data1}, frm1, q1[0]);
      end
      vectors++;
      if (frm0 !== 8'd0) begin
         miscompares++;
         $display("FAIL drop_err_isolation: got frm0=%0d want 0", frm0);
      end
      rdy1 = 1'b1;
      tick();
      void'(q1.pop_front());
      rdy1 = 1'b0;
      vectors++;
      if (rd_valid1 !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_err_drain: got valid=%0b want 0", rd_valid1);
      end
   endtask

   task automatic test_err_flags();
      par_err = 1'b1;
      tick();
      par_err = 1'b0;
      vectors++;
      if (frm0 !== 8'd0 || count0 !== 4'd0) begin
         miscompares++;
         $display("FAIL flags_without_valid: got frm=%0d count=%0d want 0 0", frm0, count0);
      end
      p_data = 8'h55; stp_err = 1'b1; data_valid = 1'b1;
      q0.push_back({2'b01, 8'h55});
      tick();
      data_valid = 1'b0; stp_err = 1'b0;
      vectors++;
      if ({rd_par0, rd_stp0, rd_data0} !== q0[0] || frm0 !== 8'd1) begin
         miscompares++;
         $display("FAIL err_flags: got head=%h frm=%0d want %h 1", {rd_par0, rd_stp0, rd_data0}, frm0, q0[0]);
      end
      rd_ready = 1'b1;
      tick();
      void'(q0.pop_front());
      rd_ready = 1'b0;
   endtask

   task automatic test_random();
      logic pop_m, full_m, dv_m;
      logic [DW+1:0] ent;
      for (int c = 0; c < 400; c++) begin
         dv_m = ($urandom_range(0, 2) != 0);
         ent = DW'($urandom_range(0, 255)) | ({$urandom_range(0, 3)} << DW);
         data_valid = dv_m; p_data = ent[DW-1:0];
         {par_err, stp_err} = ent[DW+1:DW];
         rd_ready = ($urandom_range(0, 1) == 1);
         pop_m  = (q0.size() != 0) && rd_ready;
         full_m = (q0.size() == DEPTH);
         vectors++;
         if (rd_valid0 !== (q0.size() != 0)) begin
            miscompares++;
            $display("FAIL rand_valid_%0d: got %0b want %0b", c, rd_valid0, q0.size() != 0);
         end
         if (pop_m) begin
            vectors++;
            if ({rd_par0, rd_stp0, rd_data0} !== q0[0]) begin
               miscompares++;
               $display("FAIL rand_data_%0d: got %h want %h", c, {rd_par0, rd_stp0, rd_data0}, q0[0]);
            end
         end
         tick();
         if (pop_m) void'(q0.pop_front());
         if (dv_m && (!full_m || pop_m)) q0.push_back(ent);
      end
      data_valid = 1'b0; rd_ready = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      vectors++;
      if (count0 !== 4'(q0.size())) begin
         miscompares++;
         $display("FAIL rand_count: got %0d want %0d", count0, q0.size());
      end
   endtask

   task automatic test_glitch_reset();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      strt_glitch = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      strt_glitch = 1'b0;
      vectors++;
      if (glt0 !== 8'd255 || glt1 !== 8'd255) begin
         miscompares++;
         $display("FAIL glitch_sat: got %0d %0d want 255", glt0, glt1);
      end
      clr_err = 1'b1; strt_glitch = 1'b1;
      tick();
      clr_err = 1'b0; strt_glitch = 1'b0;
      vectors++;
      if (glt0 !== 8'd0 || frm0 !== 8'd0 || ovf0 !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_err: got glitch=%0d frm=%0d ovf=%0b want 0 0 0", glt0, frm0, ovf0);
      end
      for (int i = 0; i < 3; i++) begin
         p_data = DW'(8'h80 + i); data_valid = 1'b1;
         tick();
      end
      vectors++;
      if (count0 === 4'd0) begin
         miscompares++;
         $display("FAIL pre_reset_fill: got count=%0d want nonzero", count0);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1; data_valid = 1'b0;
      q0.delete();
      vectors++;
      if (count0 !== 4'd0 || rd_valid0 !== 1'b0 || full0 !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got count=%0d valid=%0b full=%0b want 0 0 0", count0, rd_valid0, full0);
      end
   endtask

   initial begin
      test_reset();
      test_first_byte();
      test_overflow();
      test_full_pop_push();
      test_drop_err();
      test_err_flags();
      test_random();
      test_glitch_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, vectors=%0d", vectors);
      $fatal(1);
   end
endmodule
